ws2812_frame_sched: RTL and testbench

WS2812_FRAME_SCHED -- requirements
Module: ws2812_frame_sched

---
 rtl/ws2812_frame_sched_pkg.sv | 24 ++
 rtl/ws2812_gap_timer.sv | 39 +++
 rtl/ws2812_frame_sched.sv | 154 +++++++++++++++
 tb/tb_ws2812_frame_sched.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_frame_sched_pkg.sv
// Shared defaults, FSM encoding and pixel type for the WS2812 frame scheduler.
// The parameter defaults describe one 8x8 matrix driven from a 50 MHz system clock.
package ws2812_frame_sched_pkg;

    localparam int NUM_PIX_DEF    = 64;
    localparam int LATCH_CYC_DEF  = 15000;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SEND,
        LATCH
    } state_t;

    // Byte order matches the WS2812 wire order: green first.
    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

endpackage

// File: rtl/ws2812_gap_timer.sv
// Reset-gap timer. A start pulse loads the full gap length, and done pulses in the
// last cycle of the gap.
module ws2812_gap_timer
    import ws2812_frame_sched_pkg::*;
#(
    parameter int LATCH_CYC = LATCH_CYC_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic start,
    output logic done
);

    localparam int CNT_W = $clog2(LATCH_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count down to zero and stop there, so the counter never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = CNT_W'(LATCH_CYC);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ws2812_frame_sched.sv
// Arbitrates whole LED frames between the game renderer and the intro animation.
// Pixels are streamed to the serial driver, and each frame ends with the reset gap.
module ws2812_frame_sched
    import ws2812_frame_sched_pkg::*;
#(
    parameter int NUM_PIX    = NUM_PIX_DEF,
    parameter int LATCH_CYC  = LATCH_CYC_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       req_game,
    input  logic                       req_intro,
    output logic                       gnt_game,
    output logic                       gnt_intro,
    output logic                       rd_en,
    output logic [$clog2(NUM_PIX)-1:0] rd_addr,
    input  grb_t                       rd_data_game,
    input  grb_t                       rd_data_intro,
    output logic                       px_valid,
    output grb_t                       px_data,
    output logic                       px_last,
    input  logic                       px_ready,
    output logic                       frame_busy,
    output logic                       frame_done
);

    localparam int IDX_W = $clog2(NUM_PIX);
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIX - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic             gnt_game_q, gnt_game_d;
    logic             gnt_intro_q, gnt_intro_d;
    grb_t             px_data_q, px_data_d;
    logic             px_valid_q, px_valid_d;
    logic             px_last_q, px_last_d;
    logic             frame_done_q, frame_done_d;
    logic             pick_intro;
    logic             gap_start;
    logic             gap_done;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        starve_d     = starve_q;
        gnt_game_d   = gnt_game_q;
        gnt_intro_d  = gnt_intro_q;
        px_data_d    = px_data_q;
        px_valid_d   = px_valid_q;
        px_last_d    = px_last_q;
        frame_done_d = 1'b0;
        pick_intro   = 1'b0;
        gap_start    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_game || req_intro) begin
                    // The game wins ties until the intro has waited STARVE_MAX frames.
                    pick_intro  = req_intro && (!req_game || starve_q == STV_W'(STARVE_MAX));
                    gnt_intro_d = pick_intro;
                    gnt_game_d  = !pick_intro;
                    if (pick_intro || !req_intro) begin
                        starve_d = '0;
                    end else if (starve_q != STV_W'(STARVE_MAX)) begin
                        starve_d = starve_q + 1'b1;
                    end
                    idx_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                px_data_d  = gnt_intro_q ? rd_data_intro : rd_data_game;
                px_valid_d = 1'b1;
                px_last_d  = (idx_q == LAST_IDX);
                state_d    = SEND;
            end
            SEND: begin
                // px_valid is always high in SEND, so px_ready alone completes the handshake.
                if (px_ready) begin
                    px_valid_d = 1'b0;
                    px_last_d  = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        gap_start = 1'b1;
                        state_d   = LATCH;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            LATCH: begin
                if (gap_done) begin
                    frame_done_d = 1'b1;
                    gnt_game_d   = 1'b0;
                    gnt_intro_d  = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            starve_q     <= '0;
            gnt_game_q   <= 1'b0;
            gnt_intro_q  <= 1'b0;
            px_data_q    <= '0;
            px_valid_q   <= 1'b0;
            px_last_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            starve_q     <= starve_d;
            gnt_game_q   <= gnt_game_d;
            gnt_intro_q  <= gnt_intro_d;
            px_data_q    <= px_data_d;
            px_valid_q   <= px_valid_d;
            px_last_q    <= px_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    ws2812_gap_timer #(
        .LATCH_CYC (LATCH_CYC)
    ) u_gap_timer (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .start   (gap_start),
        .done    (gap_done)
    );

    assign gnt_game   = gnt_game_q;
    assign gnt_intro  = gnt_intro_q;
    assign rd_en      = (state_q == FETCH);
    assign rd_addr    = idx_q;
    assign px_valid   = px_valid_q;
    assign px_data    = px_data_q;
    assign px_last    = px_last_q;
    assign frame_busy = (state_q != IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Directed bench for ws2812_frame_sched: arbitration, pixel streaming, stalls,
// mid-frame reset and the reset-gap length.
module tb_ws2812_frame_sched;

    localparam int TB_PIX    = 64;
    // A short gap keeps the multi-frame arbitration sequence brief.
    localparam int TB_LATCH  = 100;
    localparam int TB_STARVE = 4;

    logic        sys_clk;
    logic        sys_rst;
    logic        req_game;
    logic        req_intro;
    logic        gnt_game;
    logic        gnt_intro;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic [23:0] rd_data_game;
    logic [23:0] rd_data_intro;
    logic        px_valid;
    logic [23:0] px_data;
    logic        px_last;
    logic        px_ready;
    logic        frame_busy;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    ws2812_frame_sched #(
        .NUM_PIX    (TB_PIX),
        .LATCH_CYC  (TB_LATCH),
        .STARVE_MAX (TB_STARVE)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .req_game      (req_game),
        .req_intro     (req_intro),
        .gnt_game      (gnt_game),
        .gnt_intro     (gnt_intro),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data_game  (rd_data_game),
        .rd_data_intro (rd_data_intro),
        .px_valid      (px_valid),
        .px_data       (px_data),
        .px_last       (px_last),
        .px_ready      (px_ready),
        .frame_busy    (frame_busy),
        .frame_done    (frame_done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt_game"},   32'(gnt_game),   0);
        check({tag, "_gnt_intro"},  32'(gnt_intro),  0);
        check({tag, "_rd_en"},      32'(rd_en),      0);
        check({tag, "_rd_addr"},    32'(rd_addr),    0);
        check({tag, "_px_valid"},   32'(px_valid),   0);
        check({tag, "_px_last"},    32'(px_last),    0);
        check({tag, "_px_data"},    32'(px_data),    0);
        check({tag, "_frame_busy"}, 32'(frame_busy), 0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
    endtask

    task automatic wait_grant();
        int n = 0;
        while (!(gnt_game || gnt_intro) && n < 20) begin
            tick();
            n++;
        end
        check("grant_seen", 32'(gnt_game | gnt_intro), 1);
        check("busy_on_grant", 32'(frame_busy), 1);
    endtask

    // Follows one pixel from its read strobe to the cycle px_valid is first seen.
    task automatic do_pixel(input int i, input logic [23:0] exp);
        int n = 0;
        while (!rd_en && n < 8) begin
            tick();
            n++;
        end
        check("rd_en_seen", 32'(rd_en), 1);
        check("rd_addr", 32'(rd_addr), 32'(i));
        n = 0;
        tick();
        while (!px_valid && n < 8) begin
            tick();
            n++;
        end
        check("px_valid_seen", 32'(px_valid), 1);
        check("px_data", 32'(px_data), 32'(exp));
        check("px_last", 32'(px_last), 32'(i == TB_PIX - 1));
        check("no_early_done", 32'(frame_done), 0);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!frame_done && n < TB_LATCH + 50) begin
            tick();
            n++;
        end
        check("frame_done_seen", 32'(frame_done), 1);
        check("gnt_game_drop", 32'(gnt_game), 0);
        check("gnt_intro_drop", 32'(gnt_intro), 0);
        check("busy_drop", 32'(frame_busy), 0);
    endtask

    initial begin
        int n;
        logic [23:0] exp_d;

        sys_rst       = 1'b1;
        req_game      = 1'b0;
        req_intro     = 1'b0;
        px_ready      = 1'b1;
        rd_data_game  = 24'h123456;
        rd_data_intro = 24'hABCDEF;
        repeat (3) tick();
        check_idle_outputs("reset");
        sys_rst = 1'b0;
        tick();
        check_idle_outputs("idle_no_req");

        // Game-only frame: address order, px_last, exact gap length.
        req_game = 1'b1;
        wait_grant();
        check("f0_gnt_game", 32'(gnt_game), 1);
        check("f0_gnt_intro", 32'(gnt_intro), 0);
        req_game = 1'b0;
        for (int i = 0; i < TB_PIX; i++) do_pixel(i, 24'h123456);
        tick();
        check("after_last_px_valid", 32'(px_valid), 0);
        check("latch_busy", 32'(frame_busy), 1);
        check("latch_gnt_held", 32'(gnt_game), 1);
        wait_done(n);
        check("gap_cycles", 32'(n), 32'(TB_LATCH));
        $display("frame 0: game, gap %0d cycles", n);
        tick();
        check("done_one_cycle", 32'(frame_done), 0);
        check("no_regrant", 32'(gnt_game), 0);

        // Both requests held: four game frames, then the starved intro frame.
        req_game  = 1'b1;
        req_intro = 1'b1;
        for (int f = 1; f <= 6; f++) begin
            wait_grant();
            check("arb_gnt_intro", 32'(gnt_intro), 32'(f == 5));
            check("arb_gnt_game", 32'(gnt_game), 32'(f != 5));
            $display("frame %0d: gnt_game=%0b gnt_intro=%0b", f, gnt_game, gnt_intro);
            if (f == 6) break;
            exp_d = (f == 5) ? 24'hABCDEF : 24'h123456;
            for (int i = 0; i < TB_PIX; i++) do_pixel(i, exp_d);
            wait_done(n);
            tick();
            check("regrant_next_cycle", 32'(gnt_game | gnt_intro), 1);
        end
        req_game  = 1'b0;
        req_intro = 1'b0;

        // Stall at pixel 17 on frame 6; a source change must not leak into px_data.
        for (int i = 0; i < 17; i++) do_pixel(i, 24'h123456);
        tick();
        px_ready = 1'b0;
        do_pixel(17, 24'h123456);
        rd_data_game = 24'h5A5A5A;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("stall_px_valid", 32'(px_valid), 1);
            check("stall_px_data", 32'(px_data), 32'h123456);
            check("stall_rd_en", 32'(rd_en), 0);
            check("stall_idx", 32'(rd_addr), 17);
        end
        px_ready = 1'b1;
        for (int i = 18; i < TB_PIX; i++) do_pixel(i, 24'h5A5A5A);
        wait_done(n);
        $display("frame 6: stalled 10 cycles at pixel 17");

        // Request dropped mid-frame: the frame still runs to completion.
        req_game = 1'b1;
        wait_grant();
        check("f7_gnt_game", 32'(gnt_game), 1);
        for (int i = 0; i < 30; i++) do_pixel(i, 24'h5A5A5A);
        req_game = 1'b0;
        for (int i = 30; i < TB_PIX; i++) do_pixel(i, 24'h5A5A5A);
        wait_done(n);
        tick();
        check("f7_no_regrant", 32'(gnt_game | gnt_intro), 0);
        $display("frame 7: req dropped at pixel 30, completed");

        // Reset at pixel 40, then an intro frame restarting from address 0.
        req_game = 1'b1;
        wait_grant();
        for (int i = 0; i <= 40; i++) do_pixel(i, 24'h5A5A5A);
        sys_rst  = 1'b1;
        req_game = 1'b0;
        tick();
        check_idle_outputs("mid_reset");
        sys_rst       = 1'b0;
        req_intro     = 1'b1;
        rd_data_intro = 24'hFF0000;
        rd_data_game  = 24'h00FF00;
        $display("frame 8: reset at pixel 40");
        wait_grant();
        check("f9_gnt_intro", 32'(gnt_intro), 1);
        check("f9_gnt_game", 32'(gnt_game), 0);
        req_intro = 1'b0;
        for (int i = 0; i < TB_PIX; i++) do_pixel(i, 24'hFF0000);
        wait_done(n);
        $display("frame 9: intro, data ff0000");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
